seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 8-digit seven-segment display.
- Sits directly upstream of the 8:1 nibble mux. It holds the 32-bit display word and drives it as the mux data input.
- Generates the 3-bit digit select for the mux and the matching active-low anode enables.
- Adds tear-free frame-boundary loading and optional leading-zero blanking.

---
 rtl/seg_scan_ctrl.sv | 70 +++++++
 tb/tb_seg_scan_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 8-digit seven-segment scan controller
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   ld       : single-cycle load strobe for din
//   din      : new display word, digit 0 = din[3:0]
//   blank_lz : 1 = blank leading zero digits (sampled on digit advance)
//   D        : registered display word for the nibble mux
//   sel      : registered digit select for the nibble mux
//   anode    : registered active-low digit enables, bit i = digit i
//   busy     : a load is pending until the next frame boundary
//   tick     : one-cycle pulse on each digit advance
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld,
  input  logic [31:0] din,
  input  logic        blank_lz,
  output logic [31:0] D,
  output logic [2:0]  sel,
  output logic [7:0]  anode,
  output logic        busy,
  output logic        tick
);
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_pend;
  logic             r_run;
  logic             w_wrap;
  logic             w_bound;
  logic [2:0]       w_nsel;
  logic [31:0]      w_nd;
  logic [7:0]       w_lz;
  logic [7:0]       w_nan;
  // The first wrap after reset lights digit 0 without advancing sel, so the
  // scan always starts at digit 0 and only later 7->0 wraps are frame edges.
  assign w_wrap  = r_cnt == CNT_W'(REFRESH_DIV - 1);
  assign w_nsel  = r_run ? sel + 3'd1 : 3'd0;
  assign w_bound = w_wrap && r_run && sel == 3'd7;
  assign w_nd    = (w_bound && busy) ? r_pend : D;
  always_comb begin
    w_lz = '0;
    for (int i = 1; i < 8; i++) w_lz[i] = blank_lz && ((w_nd >> (4 * i)) == 32'h0);
    w_nan = w_lz[w_nsel] ? 8'hFF : ~(8'h01 << w_nsel);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_pend <= '0;
      r_run  <= 1'b0;
      D      <= '0;
      sel    <= '0;
      anode  <= 8'hFF;
      busy   <= 1'b0;
      tick   <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      tick  <= w_wrap;
      if (w_wrap) begin
        sel   <= w_nsel;
        anode <= w_nan;
        r_run <= 1'b1;
      end
      if (w_bound && busy) D <= r_pend;
      if (ld) r_pend <= din;
      busy <= ld | (busy & ~w_bound);
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed plus randomized checks of seg_scan_ctrl against a slot-arithmetic model
module tb_seg_scan_ctrl;
  localparam int DIV = 4;
  logic        clk = 1'b0;
  logic        reset;
  logic        ld;
  logic [31:0] din;
  logic        blank_lz;
  logic [31:0] D;
  logic [2:0]  sel;
  logic [7:0]  anode;
  logic        busy;
  logic        tick;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n, s;
  logic [31:0] m_d, m_pend;
  logic        m_busy, m_blank, m_tick;
  logic        rb;

  seg_scan_ctrl #(.REFRESH_DIV(DIV), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .ld(ld), .din(din), .blank_lz(blank_lz),
    .D(D), .sel(sel), .anode(anode), .busy(busy), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    n = 0; s = 0; m_d = 0; m_pend = 0; m_busy = 0; m_blank = 0; m_tick = 0;
  endtask

  function automatic logic [2:0] exp_sel();
    return (s == 0) ? 3'd0 : 3'((s - 1) % 8);
  endfunction

  function automatic logic [7:0] exp_anode();
    int d;
    if (s == 0) return 8'hFF;
    d = (s - 1) % 8;
    if (m_blank && d > 0 && (m_d >> (4 * d)) == 32'h0) return 8'hFF;
    return ~(8'h01 << d);
  endfunction

  function automatic logic next_bnd();
    int nn = n + 1;
    return (nn % DIV == 0) && (nn / DIV >= 2) && ((nn / DIV - 1) % 8 == 0);
  endfunction

  task automatic check_all(input string tag);
    logic [7:0] ea = exp_anode();
    logic [2:0] es = exp_sel();
    n_tests++;
    assert (D === m_d) else begin n_fail++; $error("FAIL %s D got %h exp %h", tag, D, m_d); end
    n_tests++;
    assert (sel === es) else begin n_fail++; $error("FAIL %s sel got %0d exp %0d", tag, sel, es); end
    n_tests++;
    assert (anode === ea) else begin n_fail++; $error("FAIL %s anode got %h exp %h", tag, anode, ea); end
    n_tests++;
    assert (busy === m_busy) else begin n_fail++; $error("FAIL %s busy got %b exp %b", tag, busy, m_busy); end
    n_tests++;
    assert (tick === m_tick) else begin n_fail++; $error("FAIL %s tick got %b exp %b", tag, tick, m_tick); end
  endtask

  task automatic step(input logic l, input logic [31:0] dd, input logic b, input string tag);
    logic wrap, bnd;
    ld = l; din = dd; blank_lz = b;
    @(posedge clk);
    if (reset) begin
      n++;
      wrap = (n % DIV == 0);
      s = n / DIV;
      bnd = wrap && s >= 2 && ((s - 1) % 8 == 0);
      if (bnd && m_busy) begin m_d = m_pend; m_busy = 0; end
      if (l) begin m_pend = dd; m_busy = 1; end
      if (wrap) m_blank = b;
      m_tick = wrap;
    end
    #1 check_all(tag);
    ld = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] exp);
    n_tests++;
    assert (D === exp) else begin n_fail++; $error("FAIL %s D got %h exp %h", tag, D, exp); end
  endtask

  initial begin
    reset = 1'b0; ld = 1'b0; din = '0; blank_lz = 1'b0;
    model_reset();
    #12 check_all("reset");
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 44; i++) step(0, 0, 0, "scan");
    for (int i = 0; i < 64 && exp_sel() != 3'd2; i++) step(0, 0, 0, "t2_wait");
    step(1, 32'h1234_5678, 0, "t2_ld");
    for (int i = 0; i < 80 && m_busy; i++) step(0, 0, 0, "t2_run");
    chk_word("t2_word", 32'h1234_5678);
    for (int i = 0; i < 64 && exp_sel() != 3'd1; i++) step(0, 0, 0, "t3_wait");
    step(1, 32'hAAAA_AAAA, 0, "t3_ld1");
    step(0, 0, 0, "t3_gap");
    step(1, 32'h0000_00BB, 0, "t3_ld2");
    for (int i = 0; i < 80 && m_busy; i++) step(0, 0, 0, "t3_run");
    chk_word("t3_word", 32'h0000_00BB);
    for (int i = 0; i < 80 && !next_bnd(); i++) step(0, 0, 0, "t4_wait");
    step(1, 32'hCAFE_0001, 0, "t4_ld");
    chk_word("t4_hold", 32'h0000_00BB);
    for (int i = 0; i < 80 && m_busy; i++) step(0, 0, 0, "t4_run");
    chk_word("t4_word", 32'hCAFE_0001);
    step(1, 32'h0000_0042, 1, "t5_ld42");
    for (int i = 0; i < 72; i++) step(0, 0, 1, "t5_42");
    step(1, 32'h0, 1, "t5_ld0");
    for (int i = 0; i < 72; i++) step(0, 0, 1, "t5_0");
    rb = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) rb = ~rb;
      step($urandom_range(0, 7) == 0, $urandom >> (4 * $urandom_range(0, 8)), rb, "rand");
    end
    for (int i = 0; i < 64 && exp_sel() != 3'd4; i++) step(0, 0, 0, "t6_wait");
    step(1, 32'h0BAD_F00D, 0, "t6_ld");
    for (int i = 0; i < 64 && exp_sel() != 3'd5; i++) step(0, 0, 0, "t6_wait5");
    step(0, 0, 0, "t6_mid");
    #3 reset = 1'b0;
    model_reset();
    #1 check_all("t6_async");
    step(0, 0, 0, "t6_held");
    step(0, 0, 0, "t6_held");
    reset = 1'b1;
    for (int i = 0; i < 48; i++) step(0, 0, 0, "t6_restart");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
